// File: rtl/rtc_bus_ctrl_if.sv
// Sequencer / IO-pad signal bundle of rtc_bus_ctrl.
// bcd_err exists only when RTC_BCD_CHECK_EN is defined.
`timescale 1ns/1ps
interface rtc_bus_ctrl_if;
    logic       enable_inicio;
    logic       enable_escribir;
    logic       enable_leer;
    logic [1:0] posicion;
    logic [7:0] wr_data;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       listo;
    logic [7:0] rd_data;
    logic [1:0] rd_pos;
    logic       rd_valid;
`ifdef RTC_BCD_CHECK_EN
    logic       bcd_err;
`endif

    modport slave (
        input  enable_inicio, enable_escribir, enable_leer, posicion, wr_data, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, listo, rd_data, rd_pos, rd_valid
`ifdef RTC_BCD_CHECK_EN
        , output bcd_err
`endif
    );

    modport master (
        output enable_inicio, enable_escribir, enable_leer, posicion, wr_data, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, listo, rd_data, rd_pos, rd_valid
`ifdef RTC_BCD_CHECK_EN
        , input bcd_err
`endif
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// RTC bus engine: one multiplexed address/data cycle per sequencer position, listo pulse on completion.
// Optional macro RTC_BCD_CHECK_EN adds the bcd_err range check on captured read bytes.
`timescale 1ns/1ps
module rtc_bus_ctrl #(
    parameter int unsigned T_PH       = 4,
    parameter logic [7:0]  INIT_ADDR0 = 8'h02,
    parameter logic [7:0]  INIT_DATA0 = 8'h10,
    parameter logic [7:0]  INIT_ADDR1 = 8'h02,
    parameter logic [7:0]  INIT_DATA1 = 8'h00,
    parameter logic [7:0]  INIT_ADDR2 = 8'h10,
    parameter logic [7:0]  INIT_DATA2 = 8'hD2,
    parameter logic [7:0]  INIT_ADDR3 = 8'hF0,
    parameter logic [7:0]  TIME_ADDR0 = 8'h21,
    parameter logic [7:0]  TIME_ADDR1 = 8'h22,
    parameter logic [7:0]  TIME_ADDR2 = 8'h23
) (
    input logic           clk,
    input logic           reset,
    rtc_bus_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned POS_W  = 2;
    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(T_PH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_GAP1 = 3'd2,
        S_DATA = 3'd3,
        S_GAP2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_t               op_q, op_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [BYTE_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              rearm_q, rearm_d;

    logic [BYTE_W-1:0] ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              a_d_q, a_d_d;
    logic              listo_q, listo_d;
    logic              rd_valid_q, rd_valid_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic [POS_W-1:0]  rd_pos_q, rd_pos_d;

    logic              any_en;
    op_t               op_sel;
    logic [BYTE_W-1:0] addr_sel;
    logic [BYTE_W-1:0] data_sel;
    logic              phase_end;

    // Enable priority: inicio > escribir > leer
    always_comb begin
        any_en = bus.enable_inicio | bus.enable_escribir | bus.enable_leer;
        if (bus.enable_inicio) begin
            op_sel = OP_INIT;
        end else if (bus.enable_escribir) begin
            op_sel = OP_WRITE;
        end else begin
            op_sel = OP_READ;
        end
    end

    // Address/data lookup for the operation about to be latched
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        if (op_sel == OP_INIT) begin
            case (bus.posicion)
                2'd0:    begin addr_sel = INIT_ADDR0; data_sel = INIT_DATA0; end
                2'd1:    begin addr_sel = INIT_ADDR1; data_sel = INIT_DATA1; end
                2'd2:    begin addr_sel = INIT_ADDR2; data_sel = INIT_DATA2; end
                default: begin addr_sel = INIT_ADDR3; data_sel = '0;         end
            endcase
        end else begin
            case (bus.posicion)
                2'd0:    addr_sel = TIME_ADDR0;
                2'd1:    addr_sel = TIME_ADDR1;
                2'd2:    addr_sel = TIME_ADDR2;
                default: addr_sel = '0;
            endcase
            if (op_sel == OP_WRITE) begin
                data_sel = bus.wr_data;
            end
        end
    end

    // Next state plus output decode; outputs follow the current state one cycle later
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        op_d       = op_q;
        pos_d      = pos_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rearm_d    = 1'b0;
        ad_out_d   = ad_out_q;
        ad_oe_d    = 1'b0;
        cs_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        a_d_d      = 1'b1;
        listo_d    = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_pos_d   = rd_pos_q;
        phase_end  = (cnt_q == PH_LAST);

        case (state_q)
            S_IDLE: begin
                if (!rearm_q && any_en) begin
                    op_d   = op_sel;
                    pos_d  = bus.posicion;
                    addr_d = addr_sel;
                    data_d = data_sel;
                    // Time registers stop at position 2; position 3 only keeps the sequencer moving
                    if (op_sel != OP_INIT && bus.posicion == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
                cnt_d    = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) state_d = S_GAP1;
            end
            S_GAP1: begin
                ad_oe_d = (op_q != OP_READ);
                cnt_d   = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) state_d = S_DATA;
            end
            S_DATA: begin
                cs_n_d = 1'b0;
                if (op_q == OP_READ) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_q;
                end
                cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) state_d = S_GAP2;
            end
            S_GAP2: begin
                // First GAP2 cycle is when the pads still show the last read strobe cycle
                if (op_q == OP_READ && cnt_q == '0) begin
                    rd_data_d = bus.ad_in;
                end
                cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) state_d = S_DONE;
            end
            S_DONE: begin
                listo_d = 1'b1;
                if (op_q == OP_READ && pos_q != 2'd3) begin
                    rd_valid_d = 1'b1;
                    rd_pos_d   = pos_q;
                end
                rearm_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_INIT;
            pos_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rearm_q    <= 1'b0;
            ad_out_q   <= '0;
            ad_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_d_q      <= 1'b1;
            listo_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_pos_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            pos_q      <= pos_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rearm_q    <= rearm_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_d_q      <= a_d_d;
            listo_q    <= listo_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_pos_q   <= rd_pos_d;
        end
    end

`ifdef RTC_BCD_CHECK_EN
    logic bcd_bad;
    logic bcd_err_q, bcd_err_d;

    // Captured byte is settled by the DONE cycle that raises rd_valid_d
    always_comb begin
        bcd_bad = (rd_data_q[7:4] > 4'd9) || (rd_data_q[3:0] > 4'd9);
        if ((pos_q == 2'd0 || pos_q == 2'd1) && rd_data_q > 8'h59) bcd_bad = 1'b1;
        if (pos_q == 2'd2 && rd_data_q > 8'h23) bcd_bad = 1'b1;
        bcd_err_d = rd_valid_d && bcd_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_err_q <= 1'b0;
        end else begin
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bus.bcd_err = bcd_err_q;
`endif

    assign bus.ad_out   = ad_out_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.a_d      = a_d_q;
    assign bus.listo    = listo_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_pos   = rd_pos_q;
    assign bus.rd_valid = rd_valid_q;
endmodule
